// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: turns PS/2 set-2 scan-code bytes into snake game controls.
//   A prefix FSM (E0 extended, F0 break) decodes make codes from the arrow
//   keys and WASD into directions. Valid turns wait in a small FIFO, and each
//   accepted game tick pops one of them. Esc toggles pause and Space restarts.
// Ports:
//   clk, rst       - rising-edge clock, synchronous active-high reset
//   key_pressed    - one-cycle strobe, new byte on last_pressed
//   last_pressed   - scan-code byte
//   tick           - one-cycle game-step request
//   dir            - current direction (00 up, 01 right, 10 down, 11 left)
//   step           - one-cycle pulse the cycle after an accepted tick
//   paused         - pause state
//   restart        - one-cycle pulse the cycle after a Space make
//   q_count        - number of queued direction entries
module snake_input_ctrl #(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_pressed,
  input  logic [7:0]                last_pressed,
  input  logic                      tick,
  output logic [1:0]                dir,
  output logic                      step,
  output logic                      paused,
  output logic                      restart,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    mem [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          dir_vld;
  logic [1:0]    dir_key;
  logic          esc_make;
  logic          space_make;
  logic [1:0]    last_dir;
  logic          tick_acc;
  logic          pop;
  logic          push;

  // Prefix decoder: next state and the make-code actions for this byte
  always_comb begin
    state_nxt  = state;
    dir_vld    = 1'b0;
    dir_key    = DIR_UP;
    esc_make   = 1'b0;
    space_make = 1'b0;
    if (key_pressed) begin
      state_nxt = S_IDLE;
      unique case (state)
        S_IDLE: begin
          if (last_pressed == 8'hE0) begin
            state_nxt = S_EXT;
          end else if (last_pressed == 8'hF0) begin
            state_nxt = S_BRK;
          end else begin
            unique case (last_pressed)
              8'h1D:   begin dir_vld = 1'b1; dir_key = DIR_UP;    end
              8'h23:   begin dir_vld = 1'b1; dir_key = DIR_RIGHT; end
              8'h1B:   begin dir_vld = 1'b1; dir_key = DIR_DOWN;  end
              8'h1C:   begin dir_vld = 1'b1; dir_key = DIR_LEFT;  end
              8'h76:   esc_make   = 1'b1;
              8'h29:   space_make = 1'b1;
              default: ;
            endcase
          end
        end
        S_EXT: begin
          if (last_pressed == 8'hF0) begin
            state_nxt = S_EXT_BRK;
          end else if (last_pressed == 8'hE0) begin
            state_nxt = S_EXT;
          end else begin
            unique case (last_pressed)
              8'h75:   begin dir_vld = 1'b1; dir_key = DIR_UP;    end
              8'h74:   begin dir_vld = 1'b1; dir_key = DIR_RIGHT; end
              8'h72:   begin dir_vld = 1'b1; dir_key = DIR_DOWN;  end
              8'h6B:   begin dir_vld = 1'b1; dir_key = DIR_LEFT;  end
              default: ;
            endcase
          end
        end
        S_BRK: begin
          // Released keys are discarded. E0 after F0 still means an extended break.
          if (last_pressed == 8'hE0) state_nxt = S_EXT_BRK;
        end
        default: ;
      endcase
    end
  end

  // New turns are checked against the newest queued turn, or against dir when the queue is empty
  always_comb begin
    last_dir = dir;
    if (q_count != '0) last_dir = mem[wr_ptr - PW'(1)];
  end

  assign tick_acc = tick && !paused && !space_make;
  assign pop      = tick_acc && (q_count != '0);
  assign push     = dir_vld && !paused && (q_count != CW'(QDEPTH)) &&
                    (dir_key != last_dir) && (dir_key != (last_dir ^ 2'b10));

  // FSM, queue and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      dir     <= DIR_RIGHT;
      step    <= 1'b0;
      paused  <= 1'b0;
      restart <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else begin
      state   <= state_nxt;
      step    <= tick_acc;
      restart <= space_make;
      if (space_make) begin
        dir     <= DIR_RIGHT;
        paused  <= 1'b0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        q_count <= '0;
      end else begin
        if (esc_make) paused <= ~paused;
        if (pop) begin
          dir    <= mem[rd_ptr];
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push) begin
          mem[wr_ptr] <= dir_key;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        unique case ({push, pop})
          2'b10:   q_count <= q_count + CW'(1);
          2'b01:   q_count <= q_count - CW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_input_ctrl.sv
module tb_snake_input_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_pressed;
  logic [7:0] last_pressed;
  logic       tick;
  logic [1:0] dir;
  logic       step;
  logic       paused;
  logic       restart;
  logic [2:0] q_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_input_ctrl #(.QDEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_pressed  (key_pressed),
    .last_pressed (last_pressed),
    .tick         (tick),
    .dir          (dir),
    .step         (step),
    .paused       (paused),
    .restart      (restart),
    .q_count      (q_count)
  );

  // Inputs change on the falling edge. Outputs are read on the next falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; key_pressed = 1'b0; tick = 1'b0; last_pressed = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    key_pressed = 1'b1; last_pressed = b;
    @(negedge clk);
    key_pressed = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dir !== 2'b01)   begin errors++; $display("FAIL reset_dir got %b exp 01", dir); end
    checks++; if (step !== 1'b0)   begin errors++; $display("FAIL reset_step got %b exp 0", step); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got %b exp 0", paused); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL reset_restart got %b exp 0", restart); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_qcount got %0d exp 0", q_count); end
  endtask

  task automatic test_ext_up();
    do_reset();
    send_byte(8'hE0);
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL ext_prefix_q got %0d exp 0", q_count); end
    send_byte(8'h75);
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL ext_up_q got %0d exp 1", q_count); end
    checks++; if (dir !== 2'b01) begin errors++; $display("FAIL ext_up_dir_before got %b exp 01", dir); end
    do_tick();
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL ext_up_step got %b exp 1", step); end
    checks++; if (dir !== 2'b00) begin errors++; $display("FAIL ext_up_dir got %b exp 00", dir); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL ext_up_q_after got %0d exp 0", q_count); end
    @(negedge clk);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL ext_up_step_pulse got %b exp 0", step); end
  endtask

  task automatic test_reversal_break();
    do_reset();
    send_byte(8'h1C);
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reversal_q got %0d exp 0", q_count); end
    send_byte(8'hF0);
    send_byte(8'h1D);
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL break_q got %0d exp 0", q_count); end
    // A make of the current direction is a duplicate and gets dropped
    send_byte(8'h23);
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL dup_q got %0d exp 0", q_count); end
    // The FSM must be back in IDLE after the break
    send_byte(8'h1D);
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL after_break_q got %0d exp 1", q_count); end
  endtask

  task automatic test_fill();
    logic [7:0] keys [5];
    logic [1:0] exp_dir [4];
    keys[0] = 8'h1D; keys[1] = 8'h1C; keys[2] = 8'h1B; keys[3] = 8'h23; keys[4] = 8'h1D;
    exp_dir[0] = 2'b00; exp_dir[1] = 2'b11; exp_dir[2] = 2'b10; exp_dir[3] = 2'b01;
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(keys[i]);
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL fill_q got %0d exp 4", q_count); end
    for (int i = 0; i < 4; i++) begin
      do_tick();
      checks++; if (dir !== exp_dir[i]) begin errors++; $display("FAIL fill_dir%0d got %b exp %b", i, dir, exp_dir[i]); end
      checks++; if (step !== 1'b1) begin errors++; $display("FAIL fill_step%0d got %b exp 1", i, step); end
    end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL fill_q_empty got %0d exp 0", q_count); end
    // With the queue empty, a tick still steps but leaves dir unchanged
    do_tick();
    checks++; if (dir !== 2'b01 || step !== 1'b1) begin errors++; $display("FAIL empty_tick got dir %b step %b exp 01 1", dir, step); end
  endtask

  task automatic test_pause();
    do_reset();
    send_byte(8'h76);
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL pause_on got %b exp 1", paused); end
    do_tick();
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL pause_step got %b exp 0", step); end
    checks++; if (dir !== 2'b01) begin errors++; $display("FAIL pause_dir got %b exp 01", dir); end
    send_byte(8'h1D);
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL pause_enq got %0d exp 0", q_count); end
    send_byte(8'h76);
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL pause_off got %b exp 0", paused); end
    do_tick();
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL unpause_step got %b exp 1", step); end
  endtask

  task automatic test_restart();
    do_reset();
    send_byte(8'h1D);
    send_byte(8'h1C);
    checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL restart_pre_q got %0d exp 2", q_count); end
    key_pressed = 1'b1; last_pressed = 8'h29; tick = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0; tick = 1'b0;
    checks++; if (restart !== 1'b1) begin errors++; $display("FAIL restart_pulse got %b exp 1", restart); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL restart_step got %b exp 0", step); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL restart_q got %0d exp 0", q_count); end
    checks++; if (dir !== 2'b01) begin errors++; $display("FAIL restart_dir got %b exp 01", dir); end
    @(negedge clk);
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL restart_once got %b exp 0", restart); end
  endtask

  task automatic test_rst_mid_prefix();
    do_reset();
    send_byte(8'hE0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h75);
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rst_prefix_q got %0d exp 0", q_count); end
    checks++; if (dir !== 2'b01) begin errors++; $display("FAIL rst_prefix_dir got %b exp 01", dir); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    // Empty queue: a down key and a tick arrive together. The key is checked against
    // dir=01, so it is enqueued, and nothing is popped in the same cycle.
    key_pressed = 1'b1; last_pressed = 8'h1B; tick = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0; tick = 1'b0;
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL b2b_empty_q got %0d exp 1", q_count); end
    checks++; if (dir !== 2'b01 || step !== 1'b1) begin errors++; $display("FAIL b2b_empty got dir %b step %b exp 01 1", dir, step); end
    // Non-empty queue: a pop and a push in the same cycle leave the count unchanged
    key_pressed = 1'b1; last_pressed = 8'h1C; tick = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0; tick = 1'b0;
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL b2b_q got %0d exp 1", q_count); end
    checks++; if (dir !== 2'b10) begin errors++; $display("FAIL b2b_dir got %b exp 10", dir); end
    do_tick();
    checks++; if (dir !== 2'b11) begin errors++; $display("FAIL b2b_dir2 got %b exp 11", dir); end
  endtask

  initial begin
    rst = 1'b1; key_pressed = 1'b0; last_pressed = 8'h00; tick = 1'b0;
    test_reset();
    test_ext_up();
    test_reversal_break();
    test_fill();
    test_pause();
    test_restart();
    test_rst_mid_prefix();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
